// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - frame buffer write port arbiter: pixel stream unpacker and frame clear engine
// Stream words are split into two pixel writes; a pending clear takes the port at the next word boundary.
module fb_write_arbiter #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [2*PIX_W-1:0]    s_data,
   input  logic                  s_sof,
   input  logic                  clr_start,
   input  logic [PIX_W-1:0]      clr_color,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  frame_done,
   output logic [ADDR_W-1:0]     wraddress,
   output logic [2*PIX_W-1:0]    write_data,
   output logic                  wren
);

   localparam int FS = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(FS - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FS - 2);

   typedef enum logic [1:0] {IDLE, HI, LO, CLEAR} state_t;

   state_t                state, state_nxt;
   logic [ADDR_W-1:0]     wp, wp_nxt, wraddress_nxt, base;
   logic [PIX_W-1:0]      lo_pix, lo_pix_nxt, color, color_nxt;
   logic                  clr_pend, clr_pend_nxt, clr_busy_nxt;
   logic                  wren_nxt, clr_done_nxt, frame_done_nxt;
   logic [2*PIX_W-1:0]    write_data_nxt;
   logic                  take;

   assign s_ready = !clr_pend && (state == IDLE || state == LO);
   assign take    = s_valid && s_ready;
   assign base    = s_sof ? '0 : wp;

   always_comb begin
      state_nxt      = state;
      wp_nxt         = wp;
      lo_pix_nxt     = lo_pix;
      color_nxt      = color;
      clr_pend_nxt   = clr_pend;
      clr_busy_nxt   = clr_busy;
      wraddress_nxt  = wraddress;
      write_data_nxt = write_data;
      wren_nxt       = 1'b0;
      clr_done_nxt   = 1'b0;
      frame_done_nxt = 1'b0;

      if (clr_start && !clr_busy) begin
         clr_pend_nxt = 1'b1;
         clr_busy_nxt = 1'b1;
         color_nxt    = clr_color;
      end

      case (state)
         IDLE, LO: begin
            if (take) begin
               state_nxt      = HI;
               wraddress_nxt  = base;
               write_data_nxt = {s_data[2*PIX_W-1:PIX_W], {PIX_W{1'b0}}};
               wren_nxt       = 1'b1;
               lo_pix_nxt     = s_data[PIX_W-1:0];
               wp_nxt         = (base == LAST_WORD) ? '0 : base + ADDR_W'(2);
            end else if (clr_pend) begin
               state_nxt      = CLEAR;
               wraddress_nxt  = '0;
               write_data_nxt = {color, {PIX_W{1'b0}}};
               wren_nxt       = 1'b1;
            end else begin
               state_nxt      = IDLE;
            end
         end
         HI: begin
            // word bases are even, so the second pixel never wraps
            state_nxt      = LO;
            wraddress_nxt  = wraddress + ADDR_W'(1);
            write_data_nxt = {lo_pix, {PIX_W{1'b0}}};
            wren_nxt       = 1'b1;
            frame_done_nxt = (wraddress == LAST_WORD);
         end
         CLEAR: begin
            if (wraddress == LAST) begin
               state_nxt    = IDLE;
               clr_done_nxt = 1'b1;
               clr_busy_nxt = 1'b0;
               clr_pend_nxt = 1'b0;
            end else begin
               wraddress_nxt  = wraddress + ADDR_W'(1);
               write_data_nxt = {color, {PIX_W{1'b0}}};
               wren_nxt       = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wp         <= '0;
         lo_pix     <= '0;
         color      <= '0;
         clr_pend   <= 1'b0;
         clr_busy   <= 1'b0;
         clr_done   <= 1'b0;
         frame_done <= 1'b0;
         wraddress  <= '0;
         write_data <= '0;
         wren       <= 1'b0;
      end else begin
         state      <= state_nxt;
         wp         <= wp_nxt;
         lo_pix     <= lo_pix_nxt;
         color      <= color_nxt;
         clr_pend   <= clr_pend_nxt;
         clr_busy   <= clr_busy_nxt;
         clr_done   <= clr_done_nxt;
         frame_done <= frame_done_nxt;
         wraddress  <= wraddress_nxt;
         write_data <= write_data_nxt;
         wren       <= wren_nxt;
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed self-checking bench for fb_write_arbiter on a 16-pixel frame
module tb_fb_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [17:0] s_data;
   logic        s_sof;
   logic        clr_start;
   logic [8:0]  clr_color;
   logic        clr_busy;
   logic        clr_done;
   logic        frame_done;
   logic [18:0] wraddress;
   logic [17:0] write_data;
   logic        wren;

   int checks = 0;
   int errors = 0;

   logic [18:0] addr_q[$];
   logic [17:0] data_q[$];
   logic        fd_q[$];
   int          done_cnt = 0;
   int          fd_cnt   = 0;

   fb_write_arbiter #(.H_RES(8), .V_RES(2), .ADDR_W(19), .PIX_W(9)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_sof(s_sof), .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
      .clr_done(clr_done), .frame_done(frame_done), .wraddress(wraddress),
      .write_data(write_data), .wren(wren)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wren) begin
         addr_q.push_back(wraddress);
         data_q.push_back(write_data);
         fd_q.push_back(frame_done);
      end
      if (clr_done) done_cnt++;
      if (frame_done) fd_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic flush_q();
      addr_q.delete();
      data_q.delete();
      fd_q.delete();
   endtask

   task automatic wait_done();
      int n = 0;
      while (!clr_done && n < 40) begin
         tick();
         n++;
      end
      chk("clr_done_seen", 32'(clr_done), 32'd1);
      chk("busy_drops_with_done", 32'(clr_busy), 32'd0);
   endtask

   initial begin
      int base_done;
      int n;
      reset = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; clr_start = 1'b0; clr_color = '0;

      // 1: reset state and first word with sof
      tick(); tick(); tick();
      chk("rst_wren", 32'(wren), 0);
      chk("rst_addr", 32'(wraddress), 0);
      chk("rst_data", 32'(write_data), 0);
      chk("rst_busy", 32'(clr_busy), 0);
      chk("rst_done", 32'(clr_done), 0);
      chk("rst_fdone", 32'(frame_done), 0);
      chk("rst_ready", 32'(s_ready), 1);
      reset = 1'b0;
      s_valid = 1'b1; s_data = 18'h3FE01; s_sof = 1'b1;
      tick();
      s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
      chk("w1_hi_wren", 32'(wren), 1);
      chk("w1_hi_addr", 32'(wraddress), 0);
      chk("w1_hi_data", 32'(write_data), 32'h3FE00);
      chk("w1_hi_ready", 32'(s_ready), 0);
      tick();
      chk("w1_lo_wren", 32'(wren), 1);
      chk("w1_lo_addr", 32'(wraddress), 1);
      chk("w1_lo_data", 32'(write_data), 32'h00200);
      tick();
      chk("w1_idle_wren", 32'(wren), 0);

      // 2: eight back-to-back words fill the frame
      flush_q();
      fd_cnt = 0;
      s_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("bb_ready", 32'(s_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 0) begin
            s_data = {9'(9'h100 + i), 9'(9'h101 + i)};
            s_sof  = (i == 0);
         end else begin
            s_sof  = 1'b0;
         end
         tick();
      end
      s_valid = 1'b0;
      tick();
      chk("bb_count", 32'(addr_q.size()), 16);
      for (int i = 0; i < 16 && i < addr_q.size(); i++) begin
         chk("bb_addr", 32'(addr_q[i]), 32'(i));
         chk("bb_data", 32'(data_q[i]), 32'({9'(9'h100 + i), 9'h000}));
         chk("bb_fdone", 32'(fd_q[i]), (i == 15) ? 32'd1 : 32'd0);
      end
      chk("bb_fdone_cnt", 32'(fd_cnt), 1);
      s_valid = 1'b1; s_data = 18'h12345;
      tick();
      s_valid = 1'b0;
      chk("wrap_addr", 32'(wraddress), 0);
      chk("wrap_wren", 32'(wren), 1);
      tick();
      chk("wrap_addr_lo", 32'(wraddress), 1);
      tick();

      // 3: clear from idle
      flush_q();
      base_done = done_cnt;
      clr_start = 1'b1; clr_color = 9'h0A4;
      tick();
      clr_start = 1'b0; clr_color = '0;
      chk("clr_busy_set", 32'(clr_busy), 1);
      chk("clr_ready_low", 32'(s_ready), 0);
      wait_done();
      chk("clr_count", 32'(addr_q.size()), 16);
      for (int i = 0; i < 16 && i < addr_q.size(); i++) begin
         chk("clr_addr", 32'(addr_q[i]), 32'(i));
         chk("clr_data", 32'(data_q[i]), 32'({9'h0A4, 9'h000}));
      end
      tick();
      chk("clr_done_pulse", 32'(clr_done), 0);
      chk("clr_done_cnt", 32'(done_cnt - base_done), 1);

      // 4: clear requested while a word is mid-write
      flush_q();
      s_valid = 1'b1; s_data = {9'h0AA, 9'h0BB};
      tick();
      s_valid = 1'b0;
      clr_start = 1'b1; clr_color = 9'h155;
      tick();
      clr_start = 1'b0;
      chk("mid_lo_addr", 32'(wraddress), 3);
      chk("mid_lo_wren", 32'(wren), 1);
      chk("mid_busy", 32'(clr_busy), 1);
      chk("mid_ready", 32'(s_ready), 0);
      wait_done();
      chk("mid_count", 32'(addr_q.size()), 18);
      if (addr_q.size() >= 18) begin
         chk("mid_hi", 32'(addr_q[0]), 2);
         chk("mid_lo_d", 32'(data_q[1]), 32'({9'h0BB, 9'h000}));
         chk("mid_clr0", 32'(addr_q[2]), 0);
         chk("mid_clr15", 32'(addr_q[17]), 15);
         chk("mid_clr_d", 32'(data_q[10]), 32'({9'h155, 9'h000}));
      end
      tick();
      s_valid = 1'b1; s_data = 18'h2D2D2;
      tick();
      s_valid = 1'b0;
      chk("resume_addr", 32'(wraddress), 4);
      chk("resume_wren", 32'(wren), 1);
      tick(); tick();

      // 5: reset in the middle of a clear
      clr_start = 1'b1; clr_color = 9'h033;
      tick();
      clr_start = 1'b0;
      n = 0;
      while (!(wren && wraddress == 19'd7) && n < 30) begin
         tick();
         n++;
      end
      chk("rst_mid_reach7", 32'(wraddress), 7);
      base_done = done_cnt;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_wren", 32'(wren), 0);
      chk("rst_mid_busy", 32'(clr_busy), 0);
      chk("rst_mid_done", 32'(clr_done), 0);
      tick(); tick(); tick();
      chk("rst_mid_idle", 32'(wren), 0);
      chk("rst_mid_nodone", 32'(done_cnt - base_done), 0);
      s_valid = 1'b1; s_sof = 1'b1; s_data = 18'h1F0F0;
      tick();
      s_valid = 1'b0; s_sof = 1'b0;
      chk("rst_sof_addr", 32'(wraddress), 0);
      chk("rst_sof_wren", 32'(wren), 1);
      tick(); tick();

      // 6: second clr_start during a clear is ignored
      flush_q();
      base_done = done_cnt;
      clr_start = 1'b1; clr_color = 9'h1C7;
      tick();
      clr_start = 1'b0;
      tick(); tick(); tick();
      clr_start = 1'b1; clr_color = 9'h0FF;
      tick();
      clr_start = 1'b0;
      wait_done();
      for (int i = 0; i < 30; i++) tick();
      chk("ign_count", 32'(addr_q.size()), 16);
      for (int i = 0; i < addr_q.size(); i++)
         chk("ign_data", 32'(data_q[i]), 32'({9'h1C7, 9'h000}));
      chk("ign_done_cnt", 32'(done_cnt - base_done), 1);
      chk("ign_busy", 32'(clr_busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
